// File: rtl/d_flag_generator.sv
// Serial frame transmitter: opening flag, bit-stuffed payload (MSB first), closing flag.
// All outputs are registered; j idles high between frames.
//
// state | meaning
// IDLE  | line high, waiting for start
// OPEN  | sending opening flag 0111110
// DATA  | sending payload bits, counting consecutive ones
// STUFF | sending the stuffed 0 after four ones
// CLOSE | sending closing flag 0111110
module d_flag_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             j,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, OPEN, DATA, STUFF, CLOSE} state_t;

  state_t           state, state_n;
  logic [2:0]       fidx, fidx_n;
  logic [2:0]       ones, ones_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             j_n, busy_n, done_n;
  logic             emit_bit, emit_close;
  logic             pay_bit;

  // Flag 0111110: only the first and last positions are zero.
  function automatic logic flag_bit(input logic [2:0] i);
    return (i != 3'd0) && (i != 3'd6);
  endfunction

  assign pay_bit = sreg[WIDTH-1];

  always_comb begin
    state_n    = state;
    fidx_n     = fidx;
    ones_n     = ones;
    bcnt_n     = bcnt;
    sreg_n     = sreg;
    j_n        = 1'b1;
    busy_n     = 1'b1;
    done_n     = 1'b0;
    emit_bit   = 1'b0;
    emit_close = 1'b0;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = OPEN;
          fidx_n  = 3'd0;
          j_n     = 1'b0;
          sreg_n  = data_in;
          ones_n  = 3'd0;
          bcnt_n  = '0;
          busy_n  = 1'b1;
        end
      end
      OPEN: begin
        if (fidx == 3'd6) begin
          emit_bit = 1'b1;
        end else begin
          fidx_n = fidx + 3'd1;
          j_n    = flag_bit(fidx + 3'd1);
        end
      end
      DATA: begin
        // A pending stuff wins even after the last payload bit.
        if (ones == 3'd4) begin
          state_n = STUFF;
          j_n     = 1'b0;
          ones_n  = 3'd0;
        end else if (bcnt == BW'(WIDTH)) begin
          emit_close = 1'b1;
        end else begin
          emit_bit = 1'b1;
        end
      end
      STUFF: begin
        if (bcnt == BW'(WIDTH)) emit_close = 1'b1;
        else                    emit_bit   = 1'b1;
      end
      CLOSE: begin
        if (fidx == 3'd6) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          fidx_n = fidx + 3'd1;
          j_n    = flag_bit(fidx + 3'd1);
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    if (emit_bit) begin
      state_n = DATA;
      j_n     = pay_bit;
      sreg_n  = sreg << 1;
      bcnt_n  = bcnt + BW'(1);
      ones_n  = pay_bit ? ones + 3'd1 : 3'd0;
    end
    if (emit_close) begin
      state_n = CLOSE;
      fidx_n  = 3'd0;
      j_n     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fidx  <= 3'd0;
      ones  <= 3'd0;
      bcnt  <= '0;
      sreg  <= '0;
      j     <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      fidx  <= fidx_n;
      ones  <= ones_n;
      bcnt  <= bcnt_n;
      sreg  <= sreg_n;
      j     <= j_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_d_flag_generator.sv
// Directed bench for d_flag_generator: exact frame bits, protocol abuse, and a
// loopback through a flag-detector model with payload destuffing.
module tb_d_flag_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       j, busy, done;

  int errors = 0;
  int checks = 0;

  d_flag_generator #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .j(j), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({j, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: j/busy/done=%b expected 100", {j, busy, done});
    end
    start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({j, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL idle_cycle%0d: j/busy/done=%b expected 100", i, {j, busy, done});
      end
    end
  endtask

  // Send one frame and compare every line bit against a hand-computed vector.
  task automatic run_frame(input logic [7:0] p, input logic [63:0] exp, input int len,
                           input int abuse_at, input string name);
    @(negedge clk);
    start = 1'b1; data_in = p;
    for (int n = 0; n < len; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (j !== exp[len-1-n]) begin
        errors++;
        $display("FAIL %s_bit%0d: j=%b expected %b", name, n, j, exp[len-1-n]);
      end
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL %s_busy%0d: busy/done=%b expected 10", name, n, {busy, done});
      end
      if (n == abuse_at) begin
        start = 1'b1; data_in = ~p;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({j, busy, done} !== 3'b101) begin
      errors++;
      $display("FAIL %s_end: j/busy/done=%b expected 101", name, {j, busy, done});
    end
    @(posedge clk); #1;
    checks++;
    if ({j, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL %s_after: j/busy/done=%b expected 100", name, {j, busy, done});
    end
  endtask

  task automatic test_frames();
    run_frame(8'hA5, 64'(22'b0111110_10100101_0111110), 22, -1, "a5");
    run_frame(8'hFF, 64'(24'b0111110_11110_11110_0111110), 24, -1, "ff");
    run_frame(8'h1E, 64'(23'b0111110_000111100_0111110), 23, -1, "1e");
  endtask

  task automatic test_start_while_busy();
    run_frame(8'h5A, 64'(22'b0111110_01011010_0111110), 22, 5, "abuse");
  endtask

  task automatic test_reset_midframe();
    int saw_done;
    @(negedge clk);
    start = 1'b1; data_in = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({j, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL abort_reset: j/busy/done=%b expected 100", {j, busy, done});
    end
    rst = 1'b0;
    saw_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy || !j) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("FAIL abort_quiet: activity cycles=%0d expected 0", saw_done);
    end
    run_frame(8'hA5, 64'(22'b0111110_10100101_0111110), 22, -1, "post_abort");
  endtask

  // Loopback: detector model flags every 0111110 window seen on the line.
  task automatic test_back_to_back();
    logic [7:0] pl[20];
    logic [6:0] hist;
    logic       bits[$];
    int         wpos[$];
    int         cyc, o, nrec, stuff_bad, nb;
    logic [7:0] rec;
    hist = 7'h7F;
    for (int f = 0; f < 20; f++) pl[f] = 8'($urandom_range(0, 255));
    pl[0] = 8'hFF; pl[6] = 8'h7E; pl[12] = 8'hF8; pl[17] = 8'hFF;
    for (int f = 0; f < 20; f++) begin
      bits.delete(); wpos.delete();
      @(negedge clk);
      start = 1'b1; data_in = pl[f];
      @(posedge clk); #1;
      start = 1'b0; data_in = ~pl[f];
      cyc = 0;
      while (busy && cyc < 100) begin
        bits.push_back(j);
        hist = {hist[5:0], j};
        if (hist == 7'b0111110) wpos.push_back(bits.size() - 1);
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (cyc >= 100) begin
        errors++;
        $display("FAIL lb%0d_timeout: busy still %b after %0d cycles", f, busy, cyc);
      end
      hist = {hist[5:0], j};
      if (hist == 7'b0111110) wpos.push_back(bits.size());
      nb = bits.size();
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL lb%0d_done: done=%b expected 1", f, done);
      end
      checks++;
      if (wpos.size() != 2 || wpos[0] != 6 || wpos[1] != nb - 1) begin
        errors++;
        $display("FAIL lb%0d_w: w events=%0d first=%0d last=%0d expected 2 at 6 and %0d",
                 f, wpos.size(), (wpos.size() > 0) ? wpos[0] : -1,
                 (wpos.size() > 0) ? wpos[wpos.size()-1] : -1, nb - 1);
      end
      o = 0; nrec = 0; stuff_bad = 0; rec = 8'h00;
      for (int i = 7; i < nb - 7; i++) begin
        if (o == 4) begin
          if (bits[i] !== 1'b0) stuff_bad++;
          o = 0;
        end else begin
          rec = {rec[6:0], bits[i]};
          nrec++;
          o = bits[i] ? o + 1 : 0;
        end
      end
      checks++;
      if (nrec != 8 || rec !== pl[f] || stuff_bad != 0) begin
        errors++;
        $display("FAIL lb%0d_payload: got %h (%0d bits, %0d bad stuffs) expected %h",
                 f, rec, nrec, stuff_bad, pl[f]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_start_while_busy();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
